fetch_buffer: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Each cycle it can take the current PC, issue one word-addressed read to instruction memory over a valid/ready request channel, and accept in-order responses.
- Fetched instructions are held in a DEPTH-entry in-order slot buffer, each paired with its PC, and presented to decode over a valid/ready channel.
- A branch/jump redirect (flush) discards all buffered and in-flight fetches without stalling the memory interface.

---
 rtl/kgp_fetch_pkg.sv | 18 +
 rtl/fetch_slot_array.sv | 68 ++++++
 rtl/fetch_buffer.sv | 112 +++++++++++
 tb/tb_fetch_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   DEF_ADDR_W / DEF_INSTR_W : default PC and instruction widths
//   NOP_INSTR                : value held in empty instruction slots
//   clog2()                  : elaboration-time ceil(log2) for pointer sizing
package kgp_fetch_pkg;

    localparam int          DEF_ADDR_W  = 32;
    localparam int          DEF_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/fetch_slot_array.sv
// DEPTH-entry register file of fetch slots, each holding {pc, instr, filled}.
//   clk, reset          : clock, synchronous active-high reset
//   clear               : drop every filled bit (redirect)
//   alloc_en/idx/pc     : claim a slot for a newly issued request
//   fill_en/idx/instr   : write returned instruction data, mark slot filled
//   pop_en, head_idx    : release the head slot; head_idx also selects the read
//   head_pc/instr/filled: contents of the head slot
module fetch_slot_array
    import kgp_fetch_pkg::*;
#(
    parameter  int DEPTH   = 4,
    parameter  int ADDR_W  = DEF_ADDR_W,
    parameter  int INSTR_W = DEF_INSTR_W,
    localparam int IDX_W   = clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               alloc_en,
    input  logic [IDX_W-1:0]   alloc_idx,
    input  logic [ADDR_W-1:0]  alloc_pc,
    input  logic               fill_en,
    input  logic [IDX_W-1:0]   fill_idx,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               pop_en,
    input  logic [IDX_W-1:0]   head_idx,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic               head_filled
);

    logic [ADDR_W-1:0]  pc_all     [DEPTH];
    logic [INSTR_W-1:0] instr_all  [DEPTH];
    logic               filled_all [DEPTH];

    // The buffer's pointer discipline keeps alloc, fill and pop on distinct
    // slots in any one cycle, so the per-slot priority below only matters
    // for clear.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;

        always_ff @(posedge clk) begin
            if (reset) begin
                pc     <= '0;
                instr  <= INSTR_W'(NOP_INSTR);
                filled <= 1'b0;
            end else begin
                if (alloc_en && alloc_idx == IDX_W'(i)) pc <= alloc_pc;
                if (fill_en && fill_idx == IDX_W'(i)) instr <= fill_instr;
                if (clear)                                  filled <= 1'b0;
                else if (alloc_en && alloc_idx == IDX_W'(i)) filled <= 1'b0;
                else if (fill_en && fill_idx == IDX_W'(i))   filled <= 1'b1;
                else if (pop_en && head_idx == IDX_W'(i))    filled <= 1'b0;
            end
        end

        assign pc_all[i]     = pc;
        assign instr_all[i]  = instr;
        assign filled_all[i] = filled;
    end

    assign head_pc     = pc_all[head_idx];
    assign head_instr  = instr_all[head_idx];
    assign head_filled = filled_all[head_idx];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: issues one word read per cycle for the current PC,
// collects in-order responses into a DEPTH-slot buffer and hands {pc, instr}
// to decode. A flush discards buffered and in-flight fetches; stale responses
// still owed by memory are counted and thrown away as they arrive.
//   clk, reset                   : clock, synchronous active-high reset
//   pc_in, pc_valid, pc_advance  : PC source; pc_advance = request accepted
//   imem_req_valid/addr/ready    : memory read request channel
//   imem_rsp_valid/data          : in-order read responses
//   flush                        : redirect, kills everything in the buffer
//   out_valid/instr/pc/ready     : decode channel
module fetch_buffer
    import kgp_fetch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               pc_valid,
    output logic               pc_advance,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               out_ready
);

    localparam int IDX_W  = clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    // Back-to-back flushes can stack stale responses beyond DEPTH; headroom
    // of 16x covers any realistic memory pipeline.
    localparam int DROP_W = PTR_W + 4;
    localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);

    logic [PTR_W-1:0]  alloc_ptr, fill_ptr, head_ptr;
    logic [PTR_W-1:0]  occupancy, in_flight;
    logic [DROP_W-1:0] drop_cnt;
    logic              outstanding, rsp_drop, rsp_fill, rsp_used;
    logic              issue, pop, head_filled;

    assign occupancy   = alloc_ptr - head_ptr;
    assign in_flight   = alloc_ptr - fill_ptr;
    assign outstanding = in_flight != '0;

    // Stale responses are consumed first; only then does data land in a slot.
    assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
    assign rsp_fill = imem_rsp_valid && drop_cnt == '0 && outstanding && !flush;
    assign rsp_used = imem_rsp_valid && (drop_cnt != '0 || outstanding);

    assign imem_req_valid = !reset && pc_valid && !flush && occupancy != FULL_OCC;
    assign imem_req_addr  = pc_in;
    assign issue          = imem_req_valid && imem_req_ready;
    assign pc_advance     = issue;

    assign out_valid = !reset && !flush && head_filled && occupancy != '0;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            // Everything still owed becomes stale. A response landing in the
            // flush cycle retires one of those, whether it was already stale
            // or belonged to the stream being killed.
            drop_cnt  <= drop_cnt + DROP_W'(in_flight) - DROP_W'(rsp_used);
        end else begin
            alloc_ptr <= alloc_ptr + PTR_W'(issue);
            fill_ptr  <= fill_ptr + PTR_W'(rsp_fill);
            head_ptr  <= head_ptr + PTR_W'(pop);
            drop_cnt  <= drop_cnt - DROP_W'(rsp_drop);
        end
    end

    fetch_slot_array #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_slots (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .alloc_en    (issue),
        .alloc_idx   (alloc_ptr[IDX_W-1:0]),
        .alloc_pc    (pc_in),
        .fill_en     (rsp_fill),
        .fill_idx    (fill_ptr[IDX_W-1:0]),
        .fill_instr  (imem_rsp_data),
        .pop_en      (pop),
        .head_idx    (head_ptr[IDX_W-1:0]),
        .head_pc     (out_pc),
        .head_instr  (out_instr),
        .head_filled (head_filled)
    );

    // A response with nothing owed means memory broke the request/response pairing.
    a_rsp_owed: assert property (@(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (drop_cnt != '0 || outstanding));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  pc_in = '0;
    logic               pc_valid = 1'b0;
    logic               pc_advance;
    logic               imem_req_valid;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_req_ready = 1'b0;
    logic               imem_rsp_valid = 1'b0;
    logic [INSTR_W-1:0] imem_rsp_data = '0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
        .pc_advance(pc_advance), .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .flush(flush), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_ready(out_ready)
    );

    // Observable behaviour for one cycle; pc/instr/addr are zeroed when not valid.
    typedef struct packed {
        logic        req_valid;
        logic        advance;
        logic        out_valid;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
    } view_t;

    // Reference model: an in-order list of fetches plus a count of stale
    // responses, and a memory that answers requests in order.
    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t  bq[$];
    mreq_t mq[$];
    int    stale, cyc, last_due, mem_lat;
    view_t got, want;
    int    n_checks, n_pass;
    logic [31:0] pc_reg;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr + 32'hA000;
    endfunction

    // Present the memory response, then look at the settled outputs.
    task automatic sample();
        if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        @(negedge clk);
        want = '0;
        want.req_valid = !reset && pc_valid && !flush && bq.size() < DEPTH;
        want.advance   = want.req_valid && imem_req_ready;
        want.out_valid = !reset && !flush && bq.size() > 0 && bq[0].filled;
        if (want.req_valid) want.addr = pc_in;
        if (want.out_valid) begin
            want.pc    = bq[0].pc;
            want.instr = bq[0].instr;
        end
        got = '0;
        got.req_valid = imem_req_valid;
        got.advance   = pc_advance;
        got.out_valid = out_valid;
        if (want.req_valid) got.addr = imem_req_addr;
        if (want.out_valid) begin
            got.pc    = out_pc;
            got.instr = out_instr;
        end
    endtask

    // Clock edge: apply the cycle's events to the model.
    task automatic advance();
        bit fire, pop;
        logic [31:0] req_pc;
        fire   = want.advance;
        pop    = want.out_valid && out_ready;
        req_pc = pc_in;
        @(posedge clk);
        if (reset) begin
            bq.delete(); mq.delete(); stale = 0; last_due = 0;
        end else begin
            if (imem_rsp_valid) begin
                mq.delete(0);
                if (stale > 0) stale--;
                else begin
                    bit done = 0;
                    for (int i = 0; i < bq.size(); i++) begin
                        if (!done && !bq[i].filled) begin
                            ent_t e = bq[i];
                            e.filled = 1'b1;
                            e.instr  = imem_rsp_data;
                            bq[i] = e;
                            done = 1;
                        end
                    end
                end
            end
            if (flush) begin
                foreach (bq[i]) if (!bq[i].filled) stale++;
                bq.delete();
            end else begin
                if (pop) bq.delete(0);
                if (fire) bq.push_back('{pc: req_pc, instr: '0, filled: 1'b0});
            end
            if (fire) begin
                int d = cyc + mem_lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: req_pc, due: d});
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        imem_req_ready = 1'b0; pc_in = '0;
        repeat (2) begin sample(); advance(); end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_valid = 1'b1; pc_in = 32'h55; imem_req_ready = 1'b1;
        out_ready = 1'b1; flush = 1'b0;
        sample(); advance();
        sample();
        n_checks++;
        if ({imem_req_valid, pc_advance, out_valid, out_pc, out_instr} !== '0)
            $display("FAIL reset_outputs got rv=%b adv=%b ov=%b pc=%h ins=%h want all 0",
                     imem_req_valid, pc_advance, out_valid, out_pc, out_instr);
        else n_pass++;
        n_checks++;
        if (got !== want) $display("FAIL reset_view got %h want %h", got, want); else n_pass++;
        advance();
        reset = 1'b0; pc_valid = 1'b0;
        sample();
        n_checks++;
        if ({out_valid, imem_req_valid, out_pc, out_instr} !== '0)
            $display("FAIL post_reset got ov=%b rv=%b pc=%h ins=%h want 0", out_valid, imem_req_valid, out_pc, out_instr);
        else n_pass++;
        advance();
    endtask

    task automatic test_stream();
        int first, nexp;
        do_reset(); mem_lat = 1; pc_reg = 0; first = -1; nexp = 0;
        for (int c = 0; c < 14; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b1; flush = 1'b0;
            sample();
            n_checks++;
            if (got !== want) $display("FAIL stream c%0d got %h want %h", c, got, want); else n_pass++;
            if (out_valid) begin
                if (first < 0) first = c;
                n_checks++;
                if (out_pc !== nexp || out_instr !== mem_data(nexp))
                    $display("FAIL stream_order got pc=%h ins=%h want pc=%h", out_pc, out_instr, nexp);
                else n_pass++;
                nexp++;
            end
            if (want.advance) pc_reg++;
            advance();
        end
        n_checks++;
        if (first !== 2) $display("FAIL stream_latency got %0d want 2", first); else n_pass++;
        n_checks++;
        if (nexp !== 12) $display("FAIL stream_rate got %0d want 12", nexp); else n_pass++;
    endtask

    task automatic test_full();
        int nacc, nout;
        do_reset(); mem_lat = 1; pc_reg = 0; nacc = 0; nout = 0;
        for (int c = 0; c < 8; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b0; flush = 1'b0;
            sample();
            n_checks++;
            if (got !== want) $display("FAIL full_fill c%0d got %h want %h", c, got, want); else n_pass++;
            if (pc_advance) nacc++;
            if (want.advance) pc_reg++;
            if (c == 7) begin
                n_checks++;
                if ({imem_req_valid, pc_advance} !== 2'b00)
                    $display("FAIL full_stall got rv=%b adv=%b want 0 0", imem_req_valid, pc_advance);
                else n_pass++;
            end
            advance();
        end
        n_checks++;
        if (nacc !== 4) $display("FAIL full_count got %0d want 4", nacc); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b1;
            sample();
            n_checks++;
            if (got !== want) $display("FAIL full_drain c%0d got %h want %h", c, got, want); else n_pass++;
            if (out_valid) begin
                n_checks++;
                if (out_pc !== nout) $display("FAIL full_order got %h want %h", out_pc, nout); else n_pass++;
                nout++;
            end
            if (want.advance) pc_reg++;
            advance();
        end
        n_checks++;
        if (nout < 5) $display("FAIL full_resume got %0d pops want >=5", nout); else n_pass++;
    endtask

    task automatic test_flush_inflight();
        bit seen;
        do_reset(); mem_lat = 3; pc_reg = 10; seen = 0;
        for (int c = 0; c < 16; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b1;
            flush = (c == 3);
            sample();
            n_checks++;
            if (got !== want) $display("FAIL flush_inflight c%0d got %h want %h", c, got, want); else n_pass++;
            if (out_valid && !seen) begin
                seen = 1;
                n_checks++;
                if (out_pc !== 40 || out_instr !== mem_data(40))
                    $display("FAIL flush_first got pc=%h ins=%h want pc=%h ins=%h", out_pc, out_instr, 32'd40, mem_data(40));
                else n_pass++;
            end
            if (flush) pc_reg = 40;
            else if (want.advance) pc_reg++;
            advance();
        end
        flush = 1'b0;
        n_checks++;
        if (!seen) $display("FAIL flush_timeout got no output want pc 40"); else n_pass++;
    endtask

    task automatic test_flush_coincident();
        bit seen;
        do_reset(); mem_lat = 1; pc_reg = 0; seen = 0;
        for (int c = 0; c < 9; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b1;
            flush = (c == 3);
            sample();
            n_checks++;
            if (got !== want) $display("FAIL flush_coinc c%0d got %h want %h", c, got, want); else n_pass++;
            if (c == 3 || c == 4) begin
                n_checks++;
                if (out_valid !== 1'b0) $display("FAIL flush_nopop c%0d got ov=%b want 0", c, out_valid); else n_pass++;
            end
            if (c == 4) begin
                n_checks++;
                if (imem_req_valid !== 1'b1) $display("FAIL flush_empty got rv=%b want 1", imem_req_valid); else n_pass++;
            end
            if (out_valid && !seen) begin
                seen = (c > 3);
                if (c > 3) begin
                    n_checks++;
                    if (out_pc !== 100 || c !== 6)
                        $display("FAIL flush_redirect got pc=%h c%0d want pc=64 c6", out_pc, c);
                    else n_pass++;
                end
            end
            if (flush) pc_reg = 100;
            else if (want.advance) pc_reg++;
            advance();
        end
        flush = 1'b0;
    endtask

    task automatic test_ready_toggle();
        int nexp;
        do_reset(); mem_lat = 2; pc_reg = 0; nexp = 0;
        for (int c = 0; c < 20; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = (c % 2 == 0); out_ready = 1'b1; flush = 1'b0;
            sample();
            n_checks++;
            if (got !== want) $display("FAIL toggle c%0d got %h want %h", c, got, want); else n_pass++;
            if (out_valid) begin
                n_checks++;
                if (out_pc !== nexp) $display("FAIL toggle_order got %h want %h", out_pc, nexp); else n_pass++;
                nexp++;
            end
            if (want.advance) pc_reg++;
            advance();
        end
        n_checks++;
        if (nexp < 7) $display("FAIL toggle_count got %0d want >=7", nexp); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(); mem_lat = 1; pc_reg = 0;
        for (int c = 0; c < 3; c++) begin
            pc_valid = 1'b1; pc_in = pc_reg; imem_req_ready = 1'b1; out_ready = 1'b0; flush = 1'b0;
            sample();
            if (want.advance) pc_reg++;
            advance();
        end
        reset = 1'b1;
        sample(); advance();
        sample();
        n_checks++;
        if ({out_valid, imem_req_valid, pc_advance} !== 3'b000)
            $display("FAIL reset_mid got ov=%b rv=%b adv=%b want 0 0 0", out_valid, imem_req_valid, pc_advance);
        else n_pass++;
        advance();
        reset = 1'b0; pc_reg = 0; pc_in = 0;
        sample();
        n_checks++;
        if ({out_valid, imem_req_valid, out_pc, out_instr} !== {2'b01, 64'h0})
            $display("FAIL reset_mid_after got ov=%b rv=%b pc=%h ins=%h want 0 1 0 0", out_valid, imem_req_valid, out_pc, out_instr);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        do_reset(); pc_reg = 0;
        for (int c = 0; c < 600; c++) begin
            pc_valid = ($urandom % 4) != 0; pc_in = pc_reg;
            imem_req_ready = ($urandom % 3) != 0; out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 20) == 0; mem_lat = $urandom_range(1, 4);
            sample();
            n_checks++;
            if (got !== want) $display("FAIL random c%0d got %h want %h", c, got, want); else n_pass++;
            if (flush) pc_reg = $urandom;
            else if (want.advance) pc_reg++;
            advance();
        end
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; stale = 0; last_due = 0; mem_lat = 1;
        test_reset();
        test_stream();
        test_full();
        test_flush_inflight();
        test_flush_coincident();
        test_ready_toggle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
